// File: rtl/approx_mul_pkg.sv
// Shared definitions for the pipelined approximate multiplier.
// Optional error statistics are enabled with `APPROX_MUL_ERR_STAT_EN.
package approx_mul_pkg;

    localparam logic MODE_EXACT  = 1'b1;
    localparam logic MODE_APPROX = 1'b0;

    // Widest tag the stage payload can carry; the top uses the low TAG_W bits.
    localparam int TAG_W_MAX  = 16;
    // Widest partial product the mask helper can describe.
    localparam int MASK_W_MAX = 64;

    typedef struct packed {
        logic                 mode;
        logic [TAG_W_MAX-1:0] tag;
    } stage_pay_t;

    // Mask that keeps bits [width-1:approx_bits] and clears the low approx_bits bits.
    function automatic logic [MASK_W_MAX-1:0] pp_mask(input int width, input int approx_bits);
        logic [MASK_W_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W_MAX; i++) begin
            if (i < width && i >= approx_bits) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/approx_mul_pipe_pp.sv
// Half-width unsigned multiplier whose product is truncated in approximate mode.
// Part of approx_mul_pipe (optional `APPROX_MUL_ERR_STAT_EN does not affect this block).
module approx_pp_mul
    import approx_mul_pkg::*;
#(
    parameter int H           = 4,
    parameter int APPROX_BITS = 2
) (
    input  logic [H-1:0]   a,
    input  logic [H-1:0]   b,
    input  logic           mode,
    output logic [2*H-1:0] p
);

    localparam logic [MASK_W_MAX-1:0] MASK_FULL = pp_mask(2 * H, APPROX_BITS);
    localparam logic [2*H-1:0]        MASK      = MASK_FULL[2*H-1:0];

    logic [2*H-1:0] raw;

    assign raw = (2*H)'(a) * (2*H)'(b);
    assign p   = (mode == MODE_EXACT) ? raw : (raw & MASK);

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined approximate multiplier with valid/ready on both sides.
// Operands are split into halves; four masked partial products are summed.
// Define `APPROX_MUL_ERR_STAT_EN to add the exact shadow path and err_cnt/clr_stat.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_mode,
    output logic [TAG_W-1:0]   out_tag
`ifdef APPROX_MUL_ERR_STAT_EN
    ,
    input  logic               clr_stat,
    output logic [CNT_W-1:0]   err_cnt
`endif
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    // Each stage loads when it is empty or its occupant leaves this cycle,
    // so the ready chain is combinational from out_ready back to in_ready.
    logic load_p0, load_p1, load_p2;
    logic vld_p0, vld_p1, vld_p2;

    assign load_p2  = !vld_p2 || out_ready;
    assign load_p1  = !vld_p1 || load_p2;
    assign load_p0  = !vld_p0 || load_p1;
    assign in_ready = load_p0;

    // ---- Stage 1: operand registers ----
    logic [WIDTH-1:0] a_p0, b_p0;
    stage_pay_t       pay_p0;

    // Stage 1 occupancy
    always_ff @(posedge clk) begin
        if (!rst_n)       vld_p0 <= 1'b0;
        else if (load_p0) vld_p0 <= in_valid;
    end

    // Stage 1 payload captures only real transactions
    always_ff @(posedge clk) begin
        if (load_p0 && in_valid) begin
            a_p0   <= in_a;
            b_p0   <= in_b;
            pay_p0 <= '{mode: in_mode, tag: TAG_W_MAX'(in_tag)};
        end
    end

    // ---- Stage 2: masked partial products ----
    logic [2*H-1:0] hh_c, hl_c, lh_c, ll_c;
    logic [2*H-1:0] hh_p1, hl_p1, lh_p1, ll_p1;
    stage_pay_t     pay_p1;

    approx_pp_mul #(.H(H), .APPROX_BITS(APPROX_BITS)) u_pp_hh (
        .a(a_p0[WIDTH-1:H]), .b(b_p0[WIDTH-1:H]), .mode(pay_p0.mode), .p(hh_c));
    approx_pp_mul #(.H(H), .APPROX_BITS(APPROX_BITS)) u_pp_hl (
        .a(a_p0[WIDTH-1:H]), .b(b_p0[H-1:0]),     .mode(pay_p0.mode), .p(hl_c));
    approx_pp_mul #(.H(H), .APPROX_BITS(APPROX_BITS)) u_pp_lh (
        .a(a_p0[H-1:0]),     .b(b_p0[WIDTH-1:H]), .mode(pay_p0.mode), .p(lh_c));
    approx_pp_mul #(.H(H), .APPROX_BITS(APPROX_BITS)) u_pp_ll (
        .a(a_p0[H-1:0]),     .b(b_p0[H-1:0]),     .mode(pay_p0.mode), .p(ll_c));

    // Stage 2 occupancy
    always_ff @(posedge clk) begin
        if (!rst_n)       vld_p1 <= 1'b0;
        else if (load_p1) vld_p1 <= vld_p0;
    end

    // Stage 2 payload: the four partial products plus sideband
    always_ff @(posedge clk) begin
        if (load_p1 && vld_p0) begin
            hh_p1  <= hh_c;
            hl_p1  <= hl_c;
            lh_p1  <= lh_c;
            ll_p1  <= ll_c;
            pay_p1 <= pay_p0;
        end
    end

    // ---- Stage 3: quadrant sum, output register ----
    logic [PW-1:0] sum_c;
    logic [PW-1:0] prod_p2;
    stage_pay_t    pay_p2;

    // Full-width sum; the operands are bounded so it never wraps.
    assign sum_c = {hh_p1, {WIDTH{1'b0}}}
                 + ((PW'(hl_p1) + PW'(lh_p1)) << H)
                 + PW'(ll_p1);

    // Output stage: visible state, cleared on reset and frozen while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            prod_p2 <= '0;
            pay_p2  <= '0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                prod_p2 <= sum_c;
                pay_p2  <= pay_p1;
            end
        end
    end

    logic unused_tag_bits;

    assign unused_tag_bits = ^pay_p2.tag;
    assign out_valid       = vld_p2;
    assign out_prod        = prod_p2;
    assign out_mode        = pay_p2.mode;
    assign out_tag         = pay_p2.tag[TAG_W-1:0];

`ifdef APPROX_MUL_ERR_STAT_EN
    logic [PW-1:0] exact_p1, exact_p2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Exact shadow product alongside stage 2
    always_ff @(posedge clk) begin
        if (load_p1 && vld_p0) exact_p1 <= PW'(a_p0) * PW'(b_p0);
    end

    // Exact shadow product alongside stage 3
    always_ff @(posedge clk) begin
        if (load_p2 && vld_p1) exact_p2 <= exact_p1;
    end

    // Saturating mismatch counter; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n || clr_stat) begin
            err_cnt <= '0;
        end else if (vld_p2 && out_ready && pay_p2.mode == MODE_APPROX
                     && prod_p2 != exact_p2) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Self-checking bench for approx_mul_pipe (WIDTH=8, APPROX_BITS=2).
// Build with `APPROX_MUL_ERR_STAT_EN to also exercise the error counter.
module tb_approx_mul_pipe;

    localparam int WIDTH = 8;
    localparam int AB    = 2;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a, in_b;
    logic             in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_prod;
    logic             out_mode;
    logic [TAG_W-1:0] out_tag;
`ifdef APPROX_MUL_ERR_STAT_EN
    logic             clr_stat;
    logic [CNT_W-1:0] err_cnt;
    logic [1:0]       err_cnt2;
    logic             in_ready2, out_valid2, out_mode2;
    logic [15:0]      out_prod2;
    logic [TAG_W-1:0] out_tag2;
`endif

    approx_mul_pipe #(.WIDTH(WIDTH), .APPROX_BITS(AB), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_mode(out_mode), .out_tag(out_tag)
`ifdef APPROX_MUL_ERR_STAT_EN
        , .clr_stat(clr_stat), .err_cnt(err_cnt)
`endif
    );

`ifdef APPROX_MUL_ERR_STAT_EN
    approx_mul_pipe #(.WIDTH(WIDTH), .APPROX_BITS(AB), .TAG_W(TAG_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_prod(out_prod2), .out_mode(out_mode2), .out_tag(out_tag2),
        .clr_stat(clr_stat), .err_cnt(err_cnt2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact product, or the four quadrant products each truncated.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic mode);
        int h, lo, keep, ah, al, bh, bl;
        if (mode) return 16'(a * b);
        h    = WIDTH / 2;
        lo   = (1 << h) - 1;
        keep = ~((1 << AB) - 1);
        ah = a >> h; al = a & lo; bh = b >> h; bl = b & lo;
        return 16'((((ah * bh) & keep) << WIDTH)
                 + ((((ah * bl) & keep) + ((al * bh) & keep)) << h)
                 + ((al * bl) & keep));
    endfunction

    typedef struct {
        logic [15:0]      prod;
        logic             mode;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        q[$];
    logic        stall_prev = 1'b0;
    logic [15:0] held_prod;
    logic        held_mode;
    logic [TAG_W-1:0] held_tag;

    // Scoreboard: record accepts, check each output handshake and stall hold
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_prod", 32'(out_prod), 32'(held_prod));
                check("hold_tag", 32'({out_mode, out_tag}), 32'({held_mode, held_tag}));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got tag 0x%0h, expected none", out_tag);
                end else begin
                    e = q.pop_front();
                    check("sb_prod", 32'(out_prod), 32'(e.prod));
                    check("sb_mode", 32'(out_mode), 32'(e.mode));
                    check("sb_tag", 32'(out_tag), 32'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                e.prod = model(in_a, in_b, in_mode);
                e.mode = in_mode;
                e.tag  = in_tag;
                q.push_back(e);
            end
            stall_prev = out_valid && !out_ready;
            held_prod  = out_prod;
            held_mode  = out_mode;
            held_tag   = out_tag;
        end
    end

    // One op into an empty pipe with out_ready=1; checks latency and a literal result.
    task automatic single_op(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic mode, input logic [3:0] tag, input logic [15:0] exp);
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_tag = tag;
        @(negedge clk);
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_prod"}, 32'(out_prod), 32'(exp));
    endtask

    task automatic drain(input string name);
        int guard;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check(name, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, guard, stale;
        logic hs;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0;
        out_ready = 1'b1;
`ifdef APPROX_MUL_ERR_STAT_EN
        clr_stat = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_prod", 32'(out_prod), 32'd0);
        check("rst_mode_tag", 32'({out_mode, out_tag}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full-scale operands in both modes
        single_op("t1_exact", 8'hFF, 8'hFF, 1'b1, 4'h1, 16'hFE01);
        single_op("t1_approx", 8'hFF, 8'hFF, 1'b0, 4'h2, 16'hFCE0);

        // Small operands where masking wipes out low or high quadrants
        single_op("t2_small", 8'h03, 8'h05, 1'b0, 4'h3, 16'h000C);
        single_op("t2_hh_mask", 8'h10, 8'h10, 1'b0, 4'h4, 16'h0000);
        single_op("t2_hh_exact", 8'h10, 8'h10, 1'b1, 4'h5, 16'h0100);
        drain("t2_drained");

        // Backpressure: five tagged ops while the sink stalls for six cycles
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 8'(acc + 1); in_b = 8'h37;
            in_mode = acc[0]; in_tag = 4'(acc + 9);
            @(negedge clk);
            check("t3_ready", 32'(in_ready), 32'(acc < 3));
            if (in_valid && in_ready) acc++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        guard = 0;
        while (acc < 5 && guard < 50) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            @(posedge clk); #1;
            if (acc < 5) begin
                in_a = 8'(acc + 1); in_mode = acc[0]; in_tag = 4'(acc + 9);
            end else begin
                in_valid = 1'b0;
            end
            guard++;
        end
        check("t3_accepts", 32'(acc), 32'd5);
        drain("t3_drained");

        // Random stream with random backpressure
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
                in_mode  = 1'($urandom);
                in_tag   = 4'($urandom);
            end
            out_ready = ($urandom % 3) != 0;
        end
        drain("t4_drained");

        // Reset with three transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_a = 8'hA5; in_b = 8'(i + 3); in_mode = 1'b1; in_tag = 4'(i);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_prod", 32'(out_prod), 32'd0);
`ifdef APPROX_MUL_ERR_STAT_EN
        check("t5_err", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("t5_no_stale", 32'(stale), 32'd0);

`ifdef APPROX_MUL_ERR_STAT_EN
        // Error statistics
        @(posedge clk); #1;
        clr_stat = 1'b1;
        @(posedge clk); #1;
        clr_stat = 1'b0;
        @(negedge clk);
        check("t6_cleared", 32'(err_cnt), 32'd0);
        single_op("t6_m1", 8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFCE0);
        single_op("t6_m2", 8'hFF, 8'hFF, 1'b0, 4'h2, 16'hFCE0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_two", 32'(err_cnt), 32'd2);
        check("t6_two_small", 32'(err_cnt2), 32'd2);
        single_op("t6_m3", 8'hFF, 8'hFF, 1'b0, 4'h3, 16'hFCE0);
        clr_stat = 1'b1;
        @(posedge clk); #1;
        clr_stat = 1'b0;
        @(negedge clk);
        check("t6_clr_wins", 32'(err_cnt), 32'd0);
        check("t6_clr_wins_small", 32'(err_cnt2), 32'd0);
        for (int i = 0; i < 4; i++) single_op("t6_sat", 8'hFF, 8'hFF, 1'b0, 4'(i), 16'hFCE0);
        single_op("t6_exact", 8'hFF, 8'hFF, 1'b1, 4'h7, 16'hFE01);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_four", 32'(err_cnt), 32'd4);
        check("t6_saturated", 32'(err_cnt2), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
